// File: rtl/muldiv_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_DIV_EN to include the divide datapath; otherwise divide launches are ignored.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             r_state;
    logic [4:0]         r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_neg_q;
`ifdef MULDIV_DIV_EN
    logic               r_divzero;
    logic               r_neg_r;
    logic               r_is_div;
    logic               r_bzero;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic n);
        return n ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? (~x + 1'b1) : x;
    endfunction

    logic               w_op_ok;
    logic               w_launch;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

`ifdef MULDIV_DIV_EN
    assign w_op_ok = 1'b1;
`else
    assign w_op_ok = ~op[1];
`endif
    assign w_launch = (r_state == S_IDLE) && start && w_op_ok;
    assign w_a_neg  = op[0] & a[WIDTH-1];
    assign w_b_neg  = op[0] & b[WIDTH-1];

    // Shift-add: low half holds the remaining multiplier bits, high half the partial sum.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = neg_2w(r_acc, r_neg_q);

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;

    // Restoring step: high half is the partial remainder, quotient bits shift into the low half.
    assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
    assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                            : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_acc_next  = r_is_div ? w_div_next : w_mul_next;
    assign w_fix_hi    = r_is_div ? neg_w(r_acc[2*WIDTH-1:WIDTH], r_neg_r) : w_prod[2*WIDTH-1:WIDTH];
    assign w_fix_lo    = !r_is_div ? w_prod[WIDTH-1:0] :
                         r_bzero   ? {WIDTH{1'b1}} : neg_w(r_acc[WIDTH-1:0], r_neg_q);
    assign divzero     = r_divzero;
`else
    assign w_acc_next  = w_mul_next;
    assign w_fix_hi    = w_prod[2*WIDTH-1:WIDTH];
    assign w_fix_lo    = w_prod[WIDTH-1:0];
    assign divzero     = 1'b0;
`endif

    // Datapath registers carry no reset; they are always reloaded at launch.
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_acc   <= {{WIDTH{1'b0}}, mag(a, op[0])};
            r_opb   <= mag(b, op[0]);
            r_neg_q <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
            r_neg_r  <= w_a_neg;
            r_is_div <= op[1];
            r_bzero  <= (b == '0);
`endif
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MULDIV_DIV_EN
            r_divzero <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_divzero <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_CALC;
                        r_cnt   <= 5'd31;
                        r_busy  <= 1'b1;
                    end else if (!start) begin
                        if (mthi) r_hi <= a;
                        if (mtlo) r_lo <= a;
                    end
                end
                S_CALC: begin
                    if (r_cnt == 5'd0) r_state <= S_FIX;
                    else               r_cnt   <= r_cnt - 5'd1;
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`ifdef MULDIV_DIV_EN
                    r_divzero <= r_is_div & r_bzero;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule
